// File: rtl/idct_2d_sequencer.sv
// idct_2d_sequencer
//   Time-shares one 8-point 1-D IDCT between the row and column passes of an
//   8x8 2-D IDCT. Rows come in over in_valid/in_ready and go straight to the
//   IDCT. Row results are written row-wise into the transpose buffer T. The
//   columns of T are then issued back-to-back, and the column results are
//   collected in O. O is handed downstream over out_valid/out_ready as
//   out_col/out_idx. Lanes pass through bit-exact.
//
// Ports
//   clk, rst_n                   clock, async active-low reset
//   in_valid/in_ready/in_row     input row handshake (rows 0..7 in order)
//   out_valid/out_ready          output column handshake
//   out_col/out_idx              column j of the result, and j
//   idct_valid_in/idct_in        issue side of the 1-D IDCT
//   idct_valid_out/idct_out      result side of the 1-D IDCT (never stalls)
//   busy                         a block is in flight
//   err_unexpected, err_timeout  sticky error flags, cleared by reset only
module idct_2d_sequencer #(
    parameter int DATA_W  = 64,
    parameter int LATENCY = 9
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0][DATA_W-1:0] in_row,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0][DATA_W-1:0] out_col,
    output logic [2:0]             out_idx,
    output logic                   idct_valid_in,
    output logic [7:0][DATA_W-1:0] idct_in,
    input  logic                   idct_valid_out,
    input  logic [7:0][DATA_W-1:0] idct_out,
    output logic                   busy,
    output logic                   err_unexpected,
    output logic                   err_timeout
);
    // The wait limit is LATENCY+8 cycles, so the timer is sized to hold it
    // rather than fixed at 4 bits.
    localparam int               TMO_CYC  = LATENCY + 8;
    localparam int               TMR_W    = $clog2(TMO_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TMO_CYC - 1);

    typedef enum logic [2:0] {
        S_ROW_IN, S_ROW_WAIT, S_COL_ISSUE, S_COL_WAIT, S_OUT
    } state_t;

    state_t state, state_n;
    logic [3:0]       rows_acc, rows_acc_n, rows_cap, rows_cap_n;
    logic [3:0]       cols_iss, cols_iss_n, cols_cap, cols_cap_n;
    logic [2:0]       out_idx_n;
    logic [TMR_W-1:0] tmr, tmr_n;
    logic             accept, row_wr, col_wr, unexp, tmo;
    logic             row_vld;
    logic [7:0][DATA_W-1:0] row_q, col_word;

    logic [7:0][7:0][DATA_W-1:0] t_buf;  // t_buf[k][c] = row result k, lane c
    logic [7:0][7:0][DATA_W-1:0] o_buf;  // o_buf[j]    = column result j

    assign accept = in_valid & in_ready;

    always_comb begin
        state_n    = state;
        rows_acc_n = rows_acc;
        rows_cap_n = rows_cap;
        cols_iss_n = cols_iss;
        cols_cap_n = cols_cap;
        out_idx_n  = out_idx;
        tmr_n      = tmr;
        row_wr     = 1'b0;
        col_wr     = 1'b0;
        unexp      = 1'b0;
        tmo        = 1'b0;

        // Result routing is independent of the issue side: a result belongs to
        // whichever pass is active and still has room, otherwise it is stray.
        if (idct_valid_out) begin
            if ((state == S_ROW_IN || state == S_ROW_WAIT) && rows_cap != 4'd8) begin
                row_wr     = 1'b1;
                rows_cap_n = rows_cap + 4'd1;
            end else if ((state == S_COL_ISSUE || state == S_COL_WAIT) && cols_cap != 4'd8) begin
                col_wr     = 1'b1;
                cols_cap_n = cols_cap + 4'd1;
            end else begin
                unexp = 1'b1;
            end
        end

        case (state)
            S_ROW_IN: begin
                if (accept) begin
                    rows_acc_n = rows_acc + 4'd1;
                    if (rows_acc == 4'd7) begin
                        state_n = S_ROW_WAIT;
                        tmr_n   = '0;
                    end
                end
            end
            S_ROW_WAIT: begin
                tmr_n = tmr + TMR_W'(1);
                // Completion in the last allowed cycle wins over the timeout.
                if (rows_cap_n == 4'd8) state_n = S_COL_ISSUE;
                else if (tmr == TMR_LAST) tmo = 1'b1;
            end
            S_COL_ISSUE: begin
                cols_iss_n = cols_iss + 4'd1;
                if (cols_iss == 4'd7) begin
                    state_n = S_COL_WAIT;
                    tmr_n   = '0;
                end
            end
            S_COL_WAIT: begin
                tmr_n = tmr + TMR_W'(1);
                if (cols_cap_n == 4'd8) state_n = S_OUT;
                else if (tmr == TMR_LAST) tmo = 1'b1;
            end
            S_OUT: begin
                if (out_ready) out_idx_n = out_idx + 3'd1;
            end
            default: state_n = S_ROW_IN;
        endcase

        if (tmo || (state == S_OUT && out_ready && out_idx == 3'd7)) begin
            state_n    = S_ROW_IN;
            rows_acc_n = '0;
            rows_cap_n = '0;
            cols_iss_n = '0;
            cols_cap_n = '0;
            out_idx_n  = '0;
            tmr_n      = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_ROW_IN;
            rows_acc       <= '0;
            rows_cap       <= '0;
            cols_iss       <= '0;
            cols_cap       <= '0;
            out_idx        <= '0;
            tmr            <= '0;
            in_ready       <= 1'b0;
            row_vld        <= 1'b0;
            row_q          <= '0;
            err_unexpected <= 1'b0;
            err_timeout    <= 1'b0;
        end else begin
            state          <= state_n;
            rows_acc       <= rows_acc_n;
            rows_cap       <= rows_cap_n;
            cols_iss       <= cols_iss_n;
            cols_cap       <= cols_cap_n;
            out_idx        <= out_idx_n;
            tmr            <= tmr_n;
            in_ready       <= (state_n == S_ROW_IN) && (rows_acc_n != 4'd8);
            row_vld        <= accept;
            if (accept) row_q <= in_row;
            err_unexpected <= err_unexpected | unexp;
            err_timeout    <= err_timeout | tmo;
        end
    end

    // Data buffers carry no reset; they are always written before being read.
    always_ff @(posedge clk) begin
        if (row_wr) t_buf[rows_cap[2:0]] <= idct_out;
        if (col_wr) o_buf[cols_cap[2:0]] <= idct_out;
    end

    // Column j of T: lane r comes from row result r.
    always_comb begin
        col_word = '0;
        for (int r = 0; r < 8; r++) col_word[r] = t_buf[r][cols_iss[2:0]];
    end

    // Column issue is driven straight from the state so that column 0 goes
    // out in the cycle right after the last row result lands in T.
    assign idct_valid_in = row_vld | (state == S_COL_ISSUE);
    assign idct_in       = (state == S_COL_ISSUE) ? col_word : row_q;
    assign out_valid     = (state == S_OUT);
    assign out_col       = out_valid ? o_buf[out_idx] : '0;
    assign busy          = !(state == S_ROW_IN && rows_acc == 4'd0);

endmodule

// File: tb/tb_idct_2d_sequencer.sv
// Bench for idct_2d_sequencer. The IDCT is replaced by a LATENCY-cycle
// identity delay line, so the whole 2-D pass is a double transpose: output
// column j, lane r must equal input row r, lane j.
module tb_idct_2d_sequencer;
    localparam int DW  = 64;
    localparam int LAT = 9;

    typedef logic [7:0][DW-1:0]      row_t;
    typedef logic [7:0][7:0][DW-1:0] blk_t;

    typedef struct {
        int pat;     // 0: 8r+c, 1: random, 2: signed extremes
        int gap;     // max idle cycles before each row
        int stall;   // out_ready low cycles once out_valid appears
        int lat;     // expected first out_valid after last accept, -1 = skip
        bit inj;     // inject a stray IDCT result during the stall
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic in_valid = 1'b0, out_ready = 1'b0;
    row_t in_row = '0;
    logic in_ready, out_valid, idct_valid_in, idct_valid_out, busy;
    logic err_unexpected, err_timeout;
    logic [2:0] out_idx;
    row_t out_col, idct_in, idct_out;

    logic inject = 1'b0, drop_en = 1'b0;
    int   cyc = 0;
    int   n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    idct_2d_sequencer #(.DATA_W(DW), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_col(out_col), .out_idx(out_idx),
        .idct_valid_in(idct_valid_in), .idct_in(idct_in),
        .idct_valid_out(idct_valid_out), .idct_out(idct_out),
        .busy(busy), .err_unexpected(err_unexpected), .err_timeout(err_timeout)
    );

    // IDCT stand-in: pure delay, reset together with the DUT. With drop_en
    // the 6th issue since reset (row 5) never comes back.
    logic [LAT-1:0] dv, dk;
    row_t dd [LAT];
    int   iss_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dv      <= '0;
            dk      <= '0;
            iss_cnt <= 0;
        end else begin
            dv <= {dv[LAT-2:0], idct_valid_in};
            dk <= {dk[LAT-2:0], drop_en && idct_valid_in && iss_cnt == 5};
            if (idct_valid_in) iss_cnt <= iss_cnt + 1;
            dd[0] <= idct_in;
            for (int i = 1; i < LAT; i++) dd[i] <= dd[i-1];
        end
    end
    assign idct_valid_out = (dv[LAT-1] & ~dk[LAT-1]) | inject;
    assign idct_out       = inject ? '1 : dd[LAT-1];

    task automatic chk(input string nm, input logic [8*DW-1:0] act, input logic [8*DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic blk_t mk_blk(input int pat);
        blk_t m;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                case (pat)
                    0:       m[r][c] = DW'(8 * r + c);
                    1:       m[r][c] = {$urandom, $urandom};
                    default: m[r][c] = ((r + c) % 2 == 1) ? {1'b1, {(DW-1){1'b0}}}
                                                          : {1'b0, {(DW-1){1'b1}}};
                endcase
        return m;
    endfunction

    // Reference: column j of the result is column j of the input block.
    function automatic blk_t ref_cols(input blk_t m);
        blk_t e;
        for (int j = 0; j < 8; j++)
            for (int r = 0; r < 8; r++) e[j][r] = m[r][j];
        return e;
    endfunction

    task automatic check_rst_vals(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_idx"}, out_idx, 0);
        chk({tag, "_out_col"}, out_col, 0);
        chk({tag, "_idct_valid_in"}, idct_valid_in, 0);
        chk({tag, "_idct_in"}, idct_in, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err_unexpected"}, err_unexpected, 0);
        chk({tag, "_err_timeout"}, err_timeout, 0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #1 check_rst_vals(tag);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk({tag, "_in_ready_rise"}, in_ready, 1);
    endtask

    // Drives the 8 rows; returns the cycle of the 8th handshake.
    task automatic drive_rows(input blk_t m, input int gap, output int t_last);
        int acc = 0, guard = 0, gap_left;
        bit prev = 0;
        t_last   = 0;
        gap_left = (gap > 0) ? int'($urandom_range(gap, 0)) : 0;
        while (acc < 8 && guard < 400) begin
            @(negedge clk);
            guard++;
            chk("vin_only_on_accept", idct_valid_in, prev);
            if (acc > 0) chk("busy_in_rows", busy, 1);
            if (gap_left > 0) begin
                in_valid = 1'b0;
                gap_left--;
            end else begin
                in_valid = 1'b1;
                in_row   = m[acc];
            end
            prev = in_valid & in_ready;
            if (prev) begin
                acc++;
                t_last   = cyc;
                gap_left = (gap > 0) ? int'($urandom_range(gap, 0)) : 0;
            end
        end
        if (acc < 8) chk("row_accept_timeout", acc, 8);
        @(negedge clk);
        in_valid = 1'b0;
        in_row   = '0;
        chk("vin_last_row", idct_valid_in, 1);
        chk("in_ready_fall", in_ready, 0);
    endtask

    task automatic collect_out(input blk_t e, input int stall, input int lat,
                               input int t_last, input bit inj);
        int j = 0, guard = 0, first = -1, stall_left = stall;
        while (j < 8 && guard < 400) begin
            @(negedge clk);
            guard++;
            inject = 1'b0;
            if (out_valid) begin
                if (first < 0) begin
                    first = cyc;
                    if (lat >= 0) chk("first_valid_latency", first - t_last, lat);
                end
                chk("out_idx", out_idx, j);
                chk("out_col", out_col, e[j]);
                chk("in_ready_during_out", in_ready, 0);
                if (stall_left > 0) begin
                    out_ready = 1'b0;
                    if (inj && stall_left == 2) inject = 1'b1;
                    stall_left--;
                end else begin
                    out_ready = 1'($urandom_range(1, 0));
                end
                if (out_ready) j++;
            end else begin
                out_ready = 1'b0;
            end
        end
        if (j < 8) chk("output_timeout", j, 8);
        @(negedge clk);
        out_ready = 1'b0;
        inject    = 1'b0;
        chk("out_valid_after_last", out_valid, 0);
        chk("in_ready_after_last", in_ready, 1);
        chk("busy_idle", busy, 0);
        chk("err_unexpected", err_unexpected, inj);
    endtask

    task automatic run_block(input vec_t v);
        blk_t m;
        int t;
        m = mk_blk(v.pat);
        drive_rows(m, v.gap, t);
        collect_out(ref_cols(m), v.stall, v.lat, t, v.inj);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        blk_t m;
        int   t;

        vecs[0] = '{pat: 0, gap: 0, stall: 0,  lat: 28, inj: 0};
        vecs[1] = '{pat: 1, gap: 0, stall: 0,  lat: 28, inj: 0};
        vecs[2] = '{pat: 0, gap: 3, stall: 0,  lat: -1, inj: 0};
        vecs[3] = '{pat: 1, gap: 4, stall: 20, lat: -1, inj: 0};
        vecs[4] = '{pat: 2, gap: 0, stall: 20, lat: 28, inj: 0};
        vecs[5] = '{pat: 1, gap: 2, stall: 5,  lat: -1, inj: 1};

        do_reset("reset");
        foreach (vecs[i]) run_block(vecs[i]);

        // Row 5 result lost: timeout exactly LATENCY+8 cycles into ROW_WAIT.
        do_reset("pre_tmo");
        drop_en = 1'b1;
        m = mk_blk(1);
        drive_rows(m, 0, t);
        while (cyc < t + 17) @(negedge clk);
        chk("tmo_not_early", err_timeout, 0);
        chk("busy_in_wait", busy, 1);
        @(negedge clk);
        chk("tmo_at_limit", err_timeout, 1);
        chk("in_ready_after_tmo", in_ready, 1);
        chk("busy_after_tmo", busy, 0);
        drop_en = 1'b0;
        run_block('{pat: 0, gap: 1, stall: 3, lat: -1, inj: 0});
        chk("tmo_sticky", err_timeout, 1);

        // Reset in the middle of the column issue.
        m = mk_blk(1);
        drive_rows(m, 0, t);
        while (cyc < t + 13) @(negedge clk);
        chk("in_col_issue", idct_valid_in, 1);
        do_reset("mid_reset");
        run_block('{pat: 1, gap: 0, stall: 2, lat: 28, inj: 0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
